// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: recovers 24-bit colour words, tracks the
// word index within a frame, flags the frame reset gap and timing faults, and
// re-emits the stream after the first word like a cascaded pixel.
//
// state | meaning
// ------+-------------------------------------------------------------
// SYNC  | hunting for a clean low run of TR cycles; nothing is decoded
// IDLE  | frame boundary, line low, waiting for the first rising edge
// HI    | line high, measuring the pulse width of the current bit
// LO    | line low between bits/words, watching for the gap or reset
module ws2812_rx #(
    parameter int TH_MIN    = 8,
    parameter int TH_THRESH = 32,
    parameter int TH_MAX    = 60,
    parameter int TL_MAX    = 200,
    parameter int TR        = 2500,
    parameter int CW        = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN,
    output logic [23:0] COLOR,
    output logic        COLOR_VALID,
    output logic [7:0]  WORD_IDX,
    output logic        FRAME_END,
    output logic        BIT_ERR,
    output logic        DOUT
);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HI   = 2'd2,
        S_LO   = 2'd3
    } state_t;

    // Pulse widths are measured as cnt+1, so every threshold is compared
    // against cnt directly with the offset folded in here.
    localparam logic [CW-1:0] C_CNT_MAX = '1;
    localparam logic [CW-1:0] C_HMIN_M1 = CW'(TH_MIN - 1);
    localparam logic [CW-1:0] C_THR_M1  = CW'(TH_THRESH - 1);
    localparam logic [CW-1:0] C_HMAX    = CW'(TH_MAX);
    localparam logic [CW-1:0] C_LMAX    = CW'(TL_MAX);
    localparam logic [CW-1:0] C_TR_M1   = CW'(TR - 1);
    localparam logic [7:0]    C_WORD_MAX = 8'hFF;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_s_d;
    logic [CW-1:0]   r_cnt;
    logic [22:0]     r_shift;
    logic [4:0]      r_bit_cnt;
    logic [7:0]      r_word_cnt;
    logic [23:0]     r_color;
    logic            r_color_valid;
    logic [7:0]      r_word_idx;
    logic            r_frame_end;
    logic            r_bit_err;
    logic            r_dout_en;
    logic            r_dout;

    logic            w_s;
    logic            w_rise;
    logic            w_fall;
    logic            w_shift_en;
    logic            w_bit;
    logic            w_word_done;
    logic            w_frame_start;
    logic            w_frame_end;
    logic            w_err;

    assign w_s    = r_sync2;
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // Two-flop synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= DIN;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;
        end
    end

    // Run-length counter: restarts on every line edge, saturates at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= '0;
        end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle decode events.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_en    = 1'b0;
        w_bit         = 1'b0;
        w_word_done   = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            S_SYNC: begin
                // The fall cycle still holds the high count, so skip it.
                if (!w_s && !w_fall && (r_cnt >= C_TR_M1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_rise) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = S_HI;
                end
            end
            S_HI: begin
                if (w_fall) begin
                    if ((r_cnt < C_HMIN_M1) || (r_cnt >= C_HMAX)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_shift_en  = 1'b1;
                        w_bit       = (r_cnt >= C_THR_M1);
                        w_word_done = (r_bit_cnt == 5'd23);
                        w_state_nxt = S_LO;
                    end
                end else if (r_cnt >= C_HMAX) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_SYNC;
                end
            end
            S_LO: begin
                if (w_rise) begin
                    // A long low is only a fault inside a word; between words
                    // any gap short of the reset time is legal.
                    if ((r_bit_cnt != 5'd0) && (r_cnt >= C_LMAX)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_state_nxt = S_HI;
                    end
                end else if (r_cnt >= C_TR_M1) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    // Bit shift register and bit/word counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_shift[21:0], w_bit};
            end
            if (w_frame_start || w_frame_end || w_err || w_word_done) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_frame_start || w_frame_end || w_err) begin
                r_word_cnt <= '0;
            end else if (w_word_done && (r_word_cnt != C_WORD_MAX)) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end
        end
    end

    // Registered word output and one-cycle status strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_color       <= '0;
            r_word_idx    <= '0;
            r_color_valid <= 1'b0;
            r_frame_end   <= 1'b0;
            r_bit_err     <= 1'b0;
        end else begin
            if (w_word_done) begin
                r_color    <= {r_shift, w_bit};
                r_word_idx <= r_word_cnt;
            end
            r_color_valid <= w_word_done;
            r_frame_end   <= w_frame_end;
            r_bit_err     <= w_err | (w_frame_end & (r_bit_cnt != 5'd0));
        end
    end

    // Cascade output: first word is consumed, later traffic is forwarded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dout_en <= 1'b0;
            r_dout    <= 1'b0;
        end else begin
            if (w_err || w_frame_end) begin
                r_dout_en <= 1'b0;
            end else if (w_word_done) begin
                r_dout_en <= 1'b1;
            end
            r_dout <= (r_dout_en && !w_err && !w_frame_end) ? w_s : 1'b0;
        end
    end

    assign COLOR       = r_color;
    assign COLOR_VALID = r_color_valid;
    assign WORD_IDX    = r_word_idx;
    assign FRAME_END   = r_frame_end;
    assign BIT_ERR     = r_bit_err;
    assign DOUT        = r_dout;

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receiver/decoder for the single-wire WS2812 NRZ stream produced by the team's LED driver; clocked at 50 MHz, all timing counted in CLK cycles.
- Recovers 24-bit colour words, counts pixels per frame and detects the reset gap that ends a frame.
- Regenerates the downstream stream like a cascaded WS2812 pixel.
- Used as an on-chip loopback checker for the driver and as a pixel-emulating input stage.

Parameters:
- TH_MIN, 8: high pulse shorter than this is a glitch/error.
- TH_THRESH, 32: high count >= this decodes as 1, below as 0.
- TH_MAX, 60: high pulse longer than this is an error.
- TL_MAX, 200: mid-word low gap longer than this, but shorter than TR, is an error.
- TR, 2500: low time >= this is a frame reset (50 us).
- CW, 12: width of the timing counter.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-high reset.
- DIN  in  1  asynchronous serial input line.
- COLOR  out  24  last decoded word; first received bit at [23].
- COLOR_VALID  out  1  one-cycle strobe, COLOR updated.
- WORD_IDX  out  8  index of word in COLOR within its frame, 0-based.
- FRAME_END  out  1  one-cycle strobe, reset gap detected after at least one bit.
- BIT_ERR  out  1  one-cycle strobe, timing violation or partial word.
- DOUT  out  1  cascade output.

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. All outputs are 0 during and after reset; synchronizer flops are 0; state = SYNC.
- DIN passes a 2-flop synchronizer giving s. Edges are detected against a registered copy s_d.
  - rise: s=1, s_d=0.
  - fall: s=0, s_d=1.
- Timing counter cnt (CW bits, saturating at all-ones):
  - Cleared on every edge of s; otherwise increments.
  - High time = cnt at the fall cycle + 1.
- States:
  - SYNC: wait for a low run of TR cycles (s=0 with cnt >= TR-1), then go to IDLE. Any high restarts the wait. No decoding in SYNC.
  - IDLE: frame boundary, line low. On rise go to HI, with bit_cnt=0 and WORD_IDX counter=0.
  - HI: on fall, classify the high time h:
    - h < TH_MIN or h > TH_MAX: error.
    - otherwise bit = (h >= TH_THRESH); shift into the 24-bit shift register MSB-first; bit_cnt++; go to LO.
    - If still high when cnt reaches TH_MAX: error immediately, without waiting for the fall.
  - LO:
    - On rise, go to HI.
    - If the low run reaches TR: frame end.
    - If the low run exceeds TL_MAX while bit_cnt != 0: error.
- Word complete: at the fall cycle that makes bit_cnt=24, the next cycle gives:
  - COLOR <= shift register (including the new bit) and COLOR_VALID=1 for 1 cycle.
  - WORD_IDX = words completed in this frame before this one (saturates at 255).
  - bit_cnt <= 0.
  - COLOR holds between strobes.
- Frame end, when the low run reaches TR in LO:
  - FRAME_END=1 for 1 cycle; go to IDLE; word counter <= 0.
  - If bit_cnt != 0 at that moment, also pulse BIT_ERR in the same cycle and discard the partial word.
  - A gap of TR cycles with no bit received in the frame gives no FRAME_END.
- Error:
  - BIT_ERR=1 for 1 cycle; partial word discarded; no COLOR_VALID.
  - DOUT forced 0; go to SYNC.
  - Words already completed in the frame remain valid.
- DOUT (cascade):
  - 0 while word counter == 0 (first word is consumed).
  - From the cycle after the first COLOR_VALID until FRAME_END or error, DOUT = s, i.e. the stream delayed by 3 cycles from DIN.
  - Returns to 0 in the FRAME_END cycle.
- Simultaneous events:
  - Word completion and an immediate error on the next pulse are separate: COLOR_VALID is issued first.
  - RST mid-word aborts with no strobes.
- Latency: DIN edge to classification is 3 cycles (2 sync + edge register); COLOR_VALID follows 1 cycle later.

Test Plan:
- Reset, then DIN low for 2500 cycles, then word 0xA5C3F0 with T0H=21/T0L=43 and T1H=41/T1L=23 pulses, then 2560 cycles low -> COLOR_VALID once with COLOR=0xA5C3F0 and WORD_IDX=0; FRAME_END once; BIT_ERR never; DOUT stays 0.
- Three words 0x000000, 0xFFFFFF, 0x123456 back-to-back, then reset gap -> three strobes with WORD_IDX 0,1,2; DOUT replicates words 2-3 delayed 3 cycles; FRAME_END then WORD_IDX restarts at 0 on the next frame.
- A 5-cycle high glitch at bit 7 -> BIT_ERR pulse, no COLOR_VALID; word 0x00FF00 after a 2500-cycle low decodes correctly.
- 10 bits then a 2500-cycle low -> FRAME_END and BIT_ERR in the same cycle; no COLOR_VALID.
- Boundary pulses: high of 31 and 32 cycles -> bits 0 and 1; high of 61 cycles -> BIT_ERR; low of 201 cycles mid-word -> BIT_ERR.
- RST asserted for 1 cycle at bit 15 -> all outputs 0; frame data before 2500 cycles low is ignored; the next clean frame decodes.
